posicionador_de_navios: RTL and testbench
=========================================

// Module: posicionador_de_navios
// PURPOSE
//  Ship-placement stage of the naval-battle game: the writer of the 5x7 ship map that the attack stage reads.
//  The player enters column/row/orientation per ship and pulses confirmar; each placement is validated, then stored.
//  Outputs mapa0..mapa4 (column c, bit r = row r) feed the attack stage; pronto releases the attack phase.
// PARAMETERS
//  NUM_NAVIOS  3  number of ships to place; ship k (0-based) has length k+1; legal range 1..3
// PORTS
//  clk          in   1  system clock, all state changes on rising edge
//  reset        in   1  asynchronous, active-high; clears all state
//  enable       in   1  placement phase enabled; low = clear map, return to IDLE (synchronous)
//  confirmar    in   1  confirm button level; rising edge (registered detect) = one placement request
//  coordColuna  in   3  anchor column, legal 0..4
//  coordLinha   in   3  anchor row, legal 0..6
//  orientacao   in   1  0 = horizontal (columns c..c+L-1), 1 = vertical (rows r..r+L-1)
//  mapa0..4     out  7  ship map per column, bit r set = ship cell at (c,r)
//  navioAtual   out  2  index of ship being placed (0..NUM_NAVIOS-1; holds NUM_NAVIOS-1 when pronto)
//  pronto       out  1  all ships placed; map frozen
//  LED_R/G/B    out  1  status: R = last request rejected, G = last accepted, B = waiting for input
// BEHAVIOUR
//  Reset: mapa0..4=0, navioAtual=0, pronto=0, LED_R=0, LED_G=0, LED_B=0, state=IDLE, conf_q=0.
//  Edge detect: pulso = confirmar & ~conf_q; conf_q <= confirmar every cycle; held-high confirmar = one request.
//  States: IDLE, POSICIONANDO, VALIDAR, PRONTO (2-bit encoding).
//  IDLE: enable=1 -> POSICIONANDO, LED_B=1. Map stays 0.
//  POSICIONANDO: pulso at edge N -> latch coordColuna/coordLinha/orientacao, -> VALIDAR. LED_B=1.
//  VALIDAR (one cycle, edge N+1): build candidate mask for ship length L=navioAtual+1; reject if
//   a) column>4 or row>6; b) any cell leaves the grid (c+L-1>4 horiz, r+L-1>6 vert); c) any cell already set.
//  Reject: map unchanged, LED_R=1, LED_G=0, same navioAtual, -> POSICIONANDO.
//  Accept: OR mask into mapa at edge N+1, LED_G=1, LED_R=0; if navioAtual==NUM_NAVIOS-1 -> PRONTO,
//   pronto=1, LED_B=0; else navioAtual+1, -> POSICIONANDO.
//  Latency: map/LED result visible 1 cycle after the edge detecting the request (2 clk from confirmar rise).
//  Pulses arriving in VALIDAR or PRONTO are ignored (not queued).
//  PRONTO: map, pronto, LEDs held until enable falls or reset.
//  enable=0 in any state: next edge clears mapa0..4, navioAtual=0, pronto=0, LEDs=0, -> IDLE; overrides pulso.
//  Reset mid-VALIDAR: pending placement discarded, no partial map write.
//  Candidate mask and checks are pure combinational from latched coords; no mapa bit outside the 5x7 grid exists.
// CONFIGURATION
//  ADJACENCIA_EN defined: additional reject rule d) any candidate cell orthogonally adjacent (N/S/E/W)
//   to an already-set cell is rejected (ships may not touch). Same reject response as a)-c).
//  ADJACENCIA_EN undefined: ships may touch; only rules a)-c) apply.
// TESTING
//  1 reset then enable=1 -> all outputs 0 except LED_B=1 after one clk, navioAtual=0, state POSICIONANDO.
//  2 ship0 at (c0,r0) confirm -> mapa0=7'b0000001, LED_G=1, navioAtual=1; confirmar held 5 clk -> only one placement.
//  3 ship1 horiz (c1,r2) -> mapa1=7'b0000100, mapa2=7'b0000100; ship2 vert (c4,r4) -> mapa4=7'b1110000,
//    pronto=1, LED_B=0; further pulses -> no change.
//  4 ship2 horiz at (c3,r0) -> out of grid: LED_R=1, map unchanged, navioAtual=2; coord (c5,r0) -> LED_R=1.
//  5 overlap: ship1 vert at (c0,r0) after ship0 there -> LED_R=1, mapa0 stays 7'b0000001;
//    with ADJACENCIA_EN ship1 vert (c1,r0) -> rejected, without -> accepted mapa1=7'b0000011.
//  6 enable=0 after pronto -> next clk all mapa=0, pronto=0, navioAtual=0; reset asserted in VALIDAR -> map 0 immediately.

Source files
------------

// File: rtl/posicionador_de_navios.sv
// Ship-placement stage: validates and writes ships into the 5x7 map.
// Define ADJACENCIA_EN to forbid ships touching orthogonally.
module posicionador_de_navios #(
  parameter int NUM_NAVIOS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       confirmar,
  input  logic [2:0] coordColuna,
  input  logic [2:0] coordLinha,
  input  logic       orientacao,
  output logic [6:0] mapa0,
  output logic [6:0] mapa1,
  output logic [6:0] mapa2,
  output logic [6:0] mapa3,
  output logic [6:0] mapa4,
  output logic [1:0] navioAtual,
  output logic       pronto,
  output logic       LED_R,
  output logic       LED_G,
  output logic       LED_B
);

  typedef enum logic [1:0] {
    IDLE,
    POSICIONANDO,
    VALIDAR,
    PRONTO
  } estado_t;

  localparam logic [1:0] ULTIMO = 2'(NUM_NAVIOS - 1);

  estado_t          estado;
  logic             conf_q;
  logic             pulso;
  logic [2:0]       col_q;
  logic [2:0]       lin_q;
  logic             ori_q;
  logic [4:0][6:0]  mapa_q;
  logic [4:0][6:0]  cand;
  logic [3:0]       col4;
  logic [3:0]       lin4;
  logic [3:0]       len4;
  logic [3:0]       fim_c;
  logic [3:0]       fim_l;
  logic             fora;
  logic             colide;
  logic             rejeita;

  assign pulso = confirmar & ~conf_q;
  assign col4  = {1'b0, col_q};
  assign lin4  = {1'b0, lin_q};
  assign len4  = {2'b00, navioAtual} + 4'd1;
  assign fim_c = col4 + len4 - 4'd1;
  assign fim_l = lin4 + len4 - 4'd1;

  assign fora = (col4 > 4'd4) | (lin4 > 4'd6)
              | (ori_q ? (fim_l > 4'd6)
                       : (fim_c > 4'd4));

  // Candidate cells span anchor..end along the chosen axis.
  for (genvar c = 0; c < 5; c++) begin : g_col
    for (genvar r = 0; r < 7; r++) begin : g_lin
      localparam logic [3:0] C = 4'(c);
      localparam logic [3:0] R = 4'(r);
      assign cand[c][r] = ori_q
        ? (col4 == C && lin4 <= R && R <= fim_l)
        : (lin4 == R && col4 <= C && C <= fim_c);
    end
  end

  assign colide = |(cand & mapa_q);

`ifdef ADJACENCIA_EN
  logic [4:0][6:0] viz;
  logic            toca;

  for (genvar c = 0; c < 5; c++) begin : g_viz
    logic [6:0] esq;
    logic [6:0] dir;
    if (c == 0) begin : g_e0
      assign esq = 7'd0;
    end else begin : g_e1
      assign esq = mapa_q[c-1];
    end
    if (c == 4) begin : g_d0
      assign dir = 7'd0;
    end else begin : g_d1
      assign dir = mapa_q[c+1];
    end
    assign viz[c] = mapa_q[c]
                  | (mapa_q[c] << 1)
                  | (mapa_q[c] >> 1)
                  | esq | dir;
  end

  assign toca    = |(cand & viz);
  assign rejeita = fora | colide | toca;
`else
  assign rejeita = fora | colide;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado     <= IDLE;
      conf_q     <= 1'b0;
      col_q      <= '0;
      lin_q      <= '0;
      ori_q      <= 1'b0;
      mapa_q     <= '0;
      navioAtual <= '0;
      pronto     <= 1'b0;
      LED_R      <= 1'b0;
      LED_G      <= 1'b0;
      LED_B      <= 1'b0;
    end else begin
      conf_q <= confirmar;
      if (!enable) begin
        estado     <= IDLE;
        mapa_q     <= '0;
        navioAtual <= '0;
        pronto     <= 1'b0;
        LED_R      <= 1'b0;
        LED_G      <= 1'b0;
        LED_B      <= 1'b0;
      end else begin
        unique case (estado)
          IDLE: begin
            estado <= POSICIONANDO;
            LED_B  <= 1'b1;
          end
          POSICIONANDO: begin
            if (pulso) begin
              col_q  <= coordColuna;
              lin_q  <= coordLinha;
              ori_q  <= orientacao;
              estado <= VALIDAR;
            end
          end
          VALIDAR: begin
            if (rejeita) begin
              LED_R  <= 1'b1;
              LED_G  <= 1'b0;
              estado <= POSICIONANDO;
            end else begin
              mapa_q <= mapa_q | cand;
              LED_R  <= 1'b0;
              LED_G  <= 1'b1;
              if (navioAtual == ULTIMO) begin
                estado <= PRONTO;
                pronto <= 1'b1;
                LED_B  <= 1'b0;
              end else begin
                navioAtual <= navioAtual + 2'd1;
                estado     <= POSICIONANDO;
              end
            end
          end
          PRONTO: begin
          end
        endcase
      end
    end
  end

  assign mapa0 = mapa_q[0];
  assign mapa1 = mapa_q[1];
  assign mapa2 = mapa_q[2];
  assign mapa3 = mapa_q[3];
  assign mapa4 = mapa_q[4];

endmodule

// File: tb/tb_posicionador_de_navios.sv
// Bench for posicionador_de_navios: directed table, corner sequences
// and random placements against a grid-level reference model.
module tb_posicionador_de_navios;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       confirmar;
  logic [2:0] coordColuna;
  logic [2:0] coordLinha;
  logic       orientacao;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
  logic [1:0] navioAtual;
  logic       pronto, LED_R, LED_G, LED_B;

  int ncmp = 0;
  int nerr = 0;

  posicionador_de_navios #(.NUM_NAVIOS(3)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .confirmar(confirmar),
    .coordColuna(coordColuna), .coordLinha(coordLinha),
    .orientacao(orientacao),
    .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2),
    .mapa3(mapa3), .mapa4(mapa4),
    .navioAtual(navioAtual), .pronto(pronto),
    .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  c;
    logic [2:0]  r;
    logic        o;
    logic [34:0] mapa;
    logic [1:0]  nav;
    logic        pr;
    logic        lr;
    logic        lg;
    logic        lb;
  } vec_t;

  vec_t tab[7];

  // reference model state: grid[c][r]
  logic [4:0][6:0] mm;
  int mnav;
  bit mpr, mr, mg, mb;

  function automatic logic [34:0] mapa_dut();
    return {mapa4, mapa3, mapa2, mapa1, mapa0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string t, logic [34:0] em, int en,
                         bit ep, bit er, bit eg, bit eb);
    chk({t, ".mapa"}, 64'(mapa_dut()), 64'(em));
    chk({t, ".nav"}, 64'(navioAtual), 64'(en));
    chk({t, ".pronto"}, 64'(pronto), 64'(ep));
    chk({t, ".R"}, 64'(LED_R), 64'(er));
    chk({t, ".G"}, 64'(LED_G), 64'(eg));
    chk({t, ".B"}, 64'(LED_B), 64'(eb));
  endtask

  task automatic press(int c, int r, bit o);
    coordColuna = 3'(c);
    coordLinha  = 3'(r);
    orientacao  = o;
    confirmar   = 1'b1;
    tick();
    tick();
  endtask

  task automatic release_btn();
    confirmar = 1'b0;
    tick();
  endtask

  task automatic restart();
    enable    = 1'b0;
    confirmar = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    mm = '0; mnav = 0; mpr = 0; mr = 0; mg = 0; mb = 1;
  endtask

  function automatic bit fits(int c, int r, bit o, int len,
                              logic [4:0][6:0] g);
    for (int i = 0; i < len; i++) begin
      int cc = o ? c : c + i;
      int rr = o ? r + i : r;
      if (cc > 4 || rr > 6) return 0;
      if (g[cc][rr]) return 0;
`ifdef ADJACENCIA_EN
      if (cc > 0 && g[cc-1][rr]) return 0;
      if (cc < 4 && g[cc+1][rr]) return 0;
      if (rr > 0 && g[cc][rr-1]) return 0;
      if (rr < 6 && g[cc][rr+1]) return 0;
`endif
    end
    return 1;
  endfunction

  task automatic model_req(int c, int r, bit o);
    if (mpr) return;
    if (fits(c, r, o, mnav + 1, mm)) begin
      for (int i = 0; i <= mnav; i++)
        mm[o ? c : c + i][o ? r + i : r] = 1'b1;
      mg = 1; mr = 0;
      if (mnav == 2) begin mpr = 1; mb = 0; end
      else mnav++;
    end else begin
      mr = 1; mg = 0;
    end
  endtask

  localparam logic [34:0] M1 = 35'h1;
  localparam logic [34:0] M2 =
    {7'b0, 7'b0, 7'b0000100, 7'b0000100, 7'b0000001};
  localparam logic [34:0] M3 =
    {7'b1110000, 7'b0, 7'b0000100, 7'b0000100, 7'b0000001};

  initial begin
    tab[0] = '{3'd0, 3'd0, 1'b0, M1, 2'd1, 0, 0, 1, 1};
    tab[1] = '{3'd0, 3'd0, 1'b1, M1, 2'd1, 0, 1, 0, 1};
    tab[2] = '{3'd1, 3'd2, 1'b0, M2, 2'd2, 0, 0, 1, 1};
    tab[3] = '{3'd3, 3'd0, 1'b0, M2, 2'd2, 0, 1, 0, 1};
    tab[4] = '{3'd5, 3'd0, 1'b1, M2, 2'd2, 0, 1, 0, 1};
    tab[5] = '{3'd4, 3'd4, 1'b1, M3, 2'd2, 1, 0, 1, 0};
    tab[6] = '{3'd0, 3'd3, 1'b0, M3, 2'd2, 1, 0, 1, 0};

    reset = 1'b1; enable = 1'b0; confirmar = 1'b0;
    coordColuna = '0; coordLinha = '0; orientacao = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_all("reset", '0, 0, 0, 0, 0, 0);
    enable = 1'b1;
    tick();
    chk_all("enable", '0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 7; i++) begin
      press(tab[i].c, tab[i].r, tab[i].o);
      chk_all($sformatf("tab%0d", i), tab[i].mapa, tab[i].nav,
              tab[i].pr, tab[i].lr, tab[i].lg, tab[i].lb);
      release_btn();
    end

    enable = 1'b0;
    tick();
    chk_all("disable", '0, 0, 0, 0, 0, 0);

    // adjacency: ship1 vertical right beside ship0
    restart();
    press(0, 0, 0); release_btn();
    press(1, 0, 1);
`ifdef ADJACENCIA_EN
    chk_all("adj", M1, 1, 0, 1, 0, 1);
`else
    chk_all("adj", {7'b0, 7'b0, 7'b0, 7'b0000011, 7'b0000001},
            2, 0, 0, 1, 1);
`endif
    release_btn();

    // held confirm, exact latency, reset inside VALIDAR
    restart();
    coordColuna = 3'd0; coordLinha = 3'd0; orientacao = 1'b0;
    confirmar = 1'b1;
    tick();
    chk("lat.early", 64'(mapa_dut()), 64'(0));
    tick();
    chk("lat.exact", 64'(mapa_dut()), 64'(M1));
    tick(); tick(); tick();
    chk_all("hold", M1, 1, 0, 0, 1, 1);
    release_btn();
    coordColuna = 3'd2; coordLinha = 3'd2;
    confirmar = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    chk("rstval.mapa", 64'(mapa_dut()), 64'(0));
    chk("rstval.nav", 64'(navioAtual), 64'(0));
    tick();
    reset = 1'b0;
    confirmar = 1'b0;
    tick(); tick();
    chk_all("rstval.after", '0, 0, 0, 0, 0, 1);

    // random placements against the model
    for (int e = 0; e < 20; e++) begin
      restart();
      for (int k = 0; k < 12; k++) begin
        int c = $urandom_range(0, 5);
        int r = $urandom_range(0, 7);
        bit o = 1'($urandom_range(0, 1));
        press(c, r, o);
        model_req(c, r, o);
        chk_all($sformatf("rnd%0d.%0d", e, k),
                mm, mnav, mpr, mr, mg, mb);
        release_btn();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
